// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and the two function
// implementations / result consumer it is wrapped around.
interface truth_table_sweeper_if #(
  parameter int N_VARS = 3
);
  localparam int M = 1 << N_VARS;

  logic              start;
  logic              s_a;
  logic              s_b;
  logic [N_VARS-1:0] xyz;
  logic              busy;
  logic              done;
  logic [M-1:0]      mask_a;
  logic [M-1:0]      mask_b;
  logic              mismatch;
  logic [N_VARS-1:0] first_bad;
  logic [N_VARS:0]   zeros_a;

  // Stimulus / observer side: requests sweeps, supplies the function outputs.
  modport master (
    output start, s_a, s_b,
    input  xyz, busy, done, mask_a, mask_b, mismatch, first_bad, zeros_a
  );

  // Sweeper side.
  modport slave (
    input  start, s_a, s_b,
    output xyz, busy, done, mask_a, mask_b, mismatch, first_bad, zeros_a
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks the shared input vector of two combinational implementations through
// every minterm, samples both outputs after a settle window, and builds their
// truth-table masks plus an equivalence verdict.
//
// state  | meaning
// IDLE   | waiting for start; results from the last sweep are held
// SETTLE | current minterm driven, waiting for the logic to settle
// SAMPLE | capture s_a/s_b for the current minterm, advance index
// DONE   | one-cycle completion pulse, results final
module truth_table_sweeper #(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  truth_table_sweeper_if.slave bus
);
  localparam int M  = 1 << N_VARS;
  localparam int ZW = N_VARS + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // With no settle time the sweep stays in SAMPLE and advances every cycle.
  localparam logic [1:0]        S_NEXT   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [3:0]        CNT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [N_VARS-1:0] IDX_LAST = {N_VARS{1'b1}};
  localparam logic [N_VARS-1:0] IDX_ONE  = N_VARS'(1);
  localparam logic [ZW-1:0]     ZER_ONE  = ZW'(1);

  logic [1:0]        state_q,     state_d;
  logic [N_VARS-1:0] idx_q,       idx_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [M-1:0]      mask_a_q,    mask_a_d;
  logic [M-1:0]      mask_b_q,    mask_b_d;
  logic              mismatch_q,  mismatch_d;
  logic [N_VARS-1:0] first_bad_q, first_bad_d;
  logic [ZW-1:0]     zeros_a_q,   zeros_a_d;

  // Next-state and datapath update for the sweep sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mask_a_d    = mask_a_q;
    mask_b_d    = mask_b_q;
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    zeros_a_d   = zeros_a_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_a_d    = '0;
          mask_b_d    = '0;
          mismatch_d  = 1'b0;
          first_bad_d = '0;
          zeros_a_d   = '0;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = S_NEXT;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        mask_a_d[idx_q] = bus.s_a;
        mask_b_d[idx_q] = bus.s_b;
        if (bus.s_a == 1'b0) zeros_a_d = zeros_a_q + ZER_ONE;
        // Only the first disagreement is recorded; later ones leave first_bad alone.
        if ((bus.s_a != bus.s_b) && !mismatch_q) begin
          mismatch_d  = 1'b1;
          first_bad_d = idx_q;
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_NEXT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      mask_a_q    <= '0;
      mask_b_q    <= '0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
      zeros_a_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mask_a_q    <= mask_a_d;
      mask_b_q    <= mask_b_d;
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
      zeros_a_q   <= zeros_a_d;
    end
  end

  // idx is already 0 in IDLE and DONE, so it drives xyz directly.
  assign bus.xyz       = idx_q;
  assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mask_a    = mask_a_q;
  assign bus.mask_b    = mask_b_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.first_bad = first_bad_q;
  assign bus.zeros_a   = zeros_a_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a default instance (SETTLE=1) and a
// zero-settle instance, both fed by behavioural function blocks.
module tb_truth_table_sweeper;
  localparam int N = 3;
  localparam int M = 8;
  localparam int S = 1;
  localparam int W = M * (S + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_VARS(N)) bus1 ();
  truth_table_sweeper_if #(.N_VARS(N)) bus0 ();

  truth_table_sweeper #(.N_VARS(N), .SETTLE(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1.slave)
  );
  truth_table_sweeper #(.N_VARS(N), .SETTLE(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic         use_tbl = 1'b0;
  logic [M-1:0] tbl_a   = '0;
  logic [M-1:0] tbl_b   = '0;
  logic [M-1:0] inv_b   = '0;

  logic [M-1:0] snap_ma, snap_mb;
  logic         snap_mm;
  logic [N-1:0] snap_fb;
  logic [N:0]   snap_z;
  logic         snap_ok;

  // Canonical PoS(1,2,3,6)
  function automatic logic pos_a(input logic [2:0] v);
    logic x, y, z;
    {x, y, z} = v;
    return (x | y | ~z) & (x | ~y | z) & (x | ~y | ~z) & (~x | ~y | z);
  endfunction

  // Simplified form (X|~Z)&(~Y|Z)
  function automatic logic simp_b(input logic [2:0] v);
    logic x, y, z;
    {x, y, z} = v;
    return (x | ~z) & (~y | z);
  endfunction

  // Model: lowest index at which two truth tables differ, 0 if none.
  function automatic int model_first_bad(input logic [M-1:0] a, input logic [M-1:0] b);
    for (int i = 0; i < M; i++) if (a[i] != b[i]) return i;
    return 0;
  endfunction

  always_comb begin
    bus1.s_a = use_tbl ? tbl_a[bus1.xyz] : pos_a(bus1.xyz);
    bus1.s_b = (use_tbl ? tbl_b[bus1.xyz] : simp_b(bus1.xyz)) ^ inv_b[bus1.xyz];
    bus0.s_a = tbl_a[bus0.xyz];
    bus0.s_b = tbl_b[bus0.xyz];
  end

  // One sweep on the default instance with optional extra start pulses at
  // edges poke_a/poke_b; checks the per-edge xyz/busy/done pattern and
  // snapshots the results while done is high.
  task automatic sweep1(input int poke_a, input int poke_b);
    int exp_x;
    logic exp_busy, exp_done;
    snap_ok = 1'b0;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    n_checks++;
    if (bus1.xyz !== 3'd0 || bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_accept: xyz=%0d busy=%b done=%b, required xyz=0 busy=1 done=0",
               bus1.xyz, bus1.busy, bus1.done);
    end
    for (int e = 1; e <= W + 3; e++) begin
      if (e == poke_a || e == poke_b) begin
        @(negedge clk); bus1.start = 1'b1;
        @(posedge clk); #1 bus1.start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      exp_x    = (e < W) ? e / (S + 1) : 0;
      exp_busy = (e < W);
      exp_done = (e == W);
      n_checks++;
      if (bus1.xyz !== N'(exp_x) || bus1.busy !== exp_busy || bus1.done !== exp_done) begin
        n_fail++;
        $display("FAIL sweep_edge%0d: xyz=%0d busy=%b done=%b, required xyz=%0d busy=%b done=%b",
                 e, bus1.xyz, bus1.busy, bus1.done, exp_x, exp_busy, exp_done);
      end
      if (exp_done) begin
        snap_ma = bus1.mask_a; snap_mb = bus1.mask_b; snap_mm = bus1.mismatch;
        snap_fb = bus1.first_bad; snap_z = bus1.zeros_a; snap_ok = bus1.done;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus1.start = 1'b0;
    bus0.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus1.xyz, bus1.busy, bus1.done, bus1.mask_a, bus1.mask_b, bus1.mismatch,
         bus1.first_bad, bus1.zeros_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs not all zero (mask_a=%h zeros_a=%0d)",
               bus1.mask_a, bus1.zeros_a);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_equiv();
    use_tbl = 1'b0; inv_b = '0;
    sweep1(-1, -1);
    n_checks++;
    if (!snap_ok || snap_ma !== 8'hB1 || snap_mb !== 8'hB1 || snap_mm !== 1'b0 ||
        snap_fb !== 3'd0 || snap_z !== 4'd4) begin
      n_fail++;
      $display("FAIL equiv: ma=%h mb=%h mm=%b fb=%0d z=%0d, required B1 B1 0 0 4",
               snap_ma, snap_mb, snap_mm, snap_fb, snap_z);
    end
  endtask

  task automatic test_mismatch();
    use_tbl = 1'b0; inv_b = 8'b0110_0000;
    sweep1(-1, -1);
    n_checks++;
    if (!snap_ok || snap_ma !== 8'hB1 || snap_mb !== 8'hD1 || snap_mm !== 1'b1 ||
        snap_fb !== 3'd5 || snap_z !== 4'd4) begin
      n_fail++;
      $display("FAIL mismatch: ma=%h mb=%h mm=%b fb=%0d z=%0d, required B1 D1 1 5 4",
               snap_ma, snap_mb, snap_mm, snap_fb, snap_z);
    end
    inv_b = '0;
  endtask

  // Results of the previous sweep are nonzero here; reset must clear them
  // between edges without any clock.
  task automatic test_async_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus1.xyz, bus1.busy, bus1.done, bus1.mask_a, bus1.mask_b, bus1.mismatch,
         bus1.first_bad, bus1.zeros_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: mask_a=%h mask_b=%h mm=%b fb=%0d z=%0d, required all 0",
               bus1.mask_a, bus1.mask_b, bus1.mismatch, bus1.first_bad, bus1.zeros_a);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_start_busy();
    use_tbl = 1'b0; inv_b = '0;
    sweep1(3, 10);
    n_checks++;
    if (!snap_ok || snap_ma !== 8'hB1 || snap_mm !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: done_seen=%b ma=%h mm=%b, required 1 B1 0",
               snap_ok, snap_ma, snap_mm);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    use_tbl = 1'b0; inv_b = '0;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    k = 0;
    while (bus1.xyz !== 3'd3 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    n_checks++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL reset_mid_wait: xyz=%0d never reached 3 within 20 edges", bus1.xyz);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.xyz !== 3'd0 || bus1.busy !== 1'b0 || bus1.mask_a !== 8'h00 || bus1.zeros_a !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: xyz=%0d busy=%b ma=%h z=%0d, required 0 0 00 0",
               bus1.xyz, bus1.busy, bus1.mask_a, bus1.zeros_a);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus1.xyz !== 3'd0 || bus1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: xyz=%0d busy=%b, required 0 0", bus1.xyz, bus1.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    sweep1(-1, -1);
    n_checks++;
    if (!snap_ok || snap_ma !== 8'hB1 || snap_z !== 4'd4) begin
      n_fail++;
      $display("FAIL reset_mid_resweep: done_seen=%b ma=%h z=%0d, required 1 B1 4",
               snap_ok, snap_ma, snap_z);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      use_tbl = 1'b1;
      tbl_a   = M'($urandom);
      tbl_b   = (k % 2 == 0) ? tbl_a : M'($urandom);
      sweep1(-1, -1);
      n_checks++;
      if (!snap_ok || snap_ma !== tbl_a || snap_mb !== tbl_b ||
          snap_mm !== (tbl_a != tbl_b) ||
          snap_fb !== N'(model_first_bad(tbl_a, tbl_b)) ||
          snap_z !== (N+1)'(M - $countones(tbl_a))) begin
        n_fail++;
        $display("FAIL random%0d: ma=%h mb=%h mm=%b fb=%0d z=%0d, required %h %h %b %0d %0d",
                 k, snap_ma, snap_mb, snap_mm, snap_fb, snap_z, tbl_a, tbl_b,
                 (tbl_a != tbl_b), model_first_bad(tbl_a, tbl_b), M - $countones(tbl_a));
      end
    end
    use_tbl = 1'b0;
  endtask

  // Zero settle, start held high: each sweep takes M+2 edges start to start.
  task automatic test_settle0();
    int p, l, exp_x;
    logic exp_busy, exp_done;
    p = M + 2;
    tbl_a = M'($urandom);
    tbl_b = tbl_a ^ M'(1 << $urandom_range(M - 1));
    @(negedge clk); bus0.start = 1'b1;
    for (int e = 0; e < 2 * p; e++) begin
      @(posedge clk); #1;
      l        = e % p;
      exp_x    = (l < M) ? l : 0;
      exp_busy = (l < M);
      exp_done = (l == M);
      n_checks++;
      if (bus0.xyz !== N'(exp_x) || bus0.busy !== exp_busy || bus0.done !== exp_done) begin
        n_fail++;
        $display("FAIL settle0_edge%0d: xyz=%0d busy=%b done=%b, required xyz=%0d busy=%b done=%b",
                 e, bus0.xyz, bus0.busy, bus0.done, exp_x, exp_busy, exp_done);
      end
      if (exp_done) begin
        n_checks++;
        if (bus0.mask_a !== tbl_a || bus0.mask_b !== tbl_b || bus0.mismatch !== 1'b1 ||
            bus0.first_bad !== N'(model_first_bad(tbl_a, tbl_b)) ||
            bus0.zeros_a !== (N+1)'(M - $countones(tbl_a))) begin
          n_fail++;
          $display("FAIL settle0_result%0d: ma=%h mb=%h mm=%b fb=%0d z=%0d, required %h %h 1 %0d %0d",
                   e, bus0.mask_a, bus0.mask_b, bus0.mismatch, bus0.first_bad, bus0.zeros_a,
                   tbl_a, tbl_b, model_first_bad(tbl_a, tbl_b), M - $countones(tbl_a));
        end
        tbl_a = M'($urandom);
        tbl_b = tbl_a ^ M'(1 << $urandom_range(M - 1));
      end
    end
    @(negedge clk); bus0.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equiv();
    test_mismatch();
    test_async_reset();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_settle0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
